// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU: opcodes, funct codes, mux
// encodings and the control FSM state codes.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluc_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_BRANCH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pcsrc_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/alu_dec.sv
// Funct-to-ALU-op decoder for R-type instructions; flags unsupported functs.
module alu_dec
  import cpu_defs::*;
(
  input  logic [5:0] funct,
  output aluc_t      aluc,
  output logic       legal
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    aluc  = ALU_ADD;
    legal = 1'b1;
    case (funct)
      FN_ADD:  aluc = ALU_ADD;
      FN_SUB:  aluc = ALU_SUB;
      FN_AND:  aluc = ALU_AND;
      FN_OR:   aluc = ALU_OR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/
// memory/writeback and drives every datapath select and write enable.
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic       En,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Z,
  output logic       PcEn,
  output logic       IorD,
  output logic       MemWr,
  output logic       IrWr,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWr,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] Aluc,
  output logic [1:0] PcSrc,
  output logic       Err,
  output logic [3:0] State
);

  state_t state, next_state;
  aluc_t  funct_aluc, aluc;
  srcb_t  src_b;
  pcsrc_t pc_src;
  logic   funct_legal;
  logic   pc_en, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, src_a, err;

  alu_dec u_alu_dec (
    .funct (Funct),
    .aluc  (funct_aluc),
    .legal (funct_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)   state <= S_FETCH;
    else if (En) state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_B;
    aluc       = ALU_ADD;
    pc_src     = PC_ALU;
    err        = 1'b0;
    case (state)
      S_FETCH: begin
        ir_wr      = 1'b1;
        src_b      = SRCB_FOUR;
        pc_en      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        src_b = SRCB_BRANCH;
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     if (funct_legal) next_state = S_EXEC;   else err = 1'b1;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      if (EN_ADDI)     next_state = S_ADDIEX; else err = 1'b1;
          OP_J:         if (EN_JUMP)     next_state = S_JUMP;   else err = 1'b1;
          default:      err = 1'b1;
        endcase
      end
      S_MEMADR: begin
        src_a      = 1'b1;
        src_b      = SRCB_IMM;
        next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXEC: begin
        src_a      = 1'b1;
        aluc       = funct_aluc;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
      end
      S_ADDIEX: begin
        src_a      = 1'b1;
        src_b      = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: reg_wr = 1'b1;
      S_BRANCH: begin
        src_a  = 1'b1;
        aluc   = ALU_SUB;
        pc_src = PC_ALUOUT;
        pc_en  = Z;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Write enables die on stall or reset; selects only die on reset.
  assign PcEn     = Clrn & En & pc_en;
  assign IrWr     = Clrn & En & ir_wr;
  assign MemWr    = Clrn & En & mem_wr;
  assign RegWr    = Clrn & En & reg_wr;
  assign Err      = Clrn & En & err;
  assign IorD     = Clrn & iord;
  assign RegDst   = Clrn & reg_dst;
  assign MemToReg = Clrn & mem_to_reg;
  assign AluSrcA  = Clrn & src_a;
  assign AluSrcB  = Clrn ? src_b  : SRCB_B;
  assign Aluc     = Clrn ? aluc   : ALU_ADD;
  assign PcSrc    = Clrn ? pc_src : PC_ALU;
  assign State    = state;

endmodule
